// File: rtl/dm_img_loader.sv
// rtl/dm_img_loader.sv - packs a byte stream into 32-bit words and writes them into DM
// In IDLE the CPU's DM port passes straight through; while loading the loader owns DM.
module dm_img_loader #(
  parameter int ADDR_W    = 13,
  parameter int NUM_WORDS = 196
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        byte_in,
  input  logic              byte_vld,
  output logic              byte_rdy,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_wrt_data,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_re,
  output logic              dm_we,
  output logic [31:0]       dm_wrt_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       pack_reg;
  logic [31:0]       data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    byte_rdy  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FILL;
      end
      FILL: begin
        byte_rdy = 1'b1;
        if (byte_vld && byte_cnt == 2'd3) state_nxt = WRITE;
      end
      WRITE: state_nxt = (word_cnt == LAST_WORD) ? DONE : FILL;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // addr_q/data_q are loaded on the 4th byte so WRITE drives DM purely from registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 2'd0;
      word_cnt <= '0;
      base_q   <= '0;
      addr_q   <= '0;
      pack_reg <= 32'd0;
      data_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            byte_cnt <= 2'd0;
            word_cnt <= '0;
            pack_reg <= 32'd0;
          end
        end
        FILL: begin
          if (byte_vld) begin
            pack_reg[8*byte_cnt +: 8] <= byte_in;
            byte_cnt                  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              addr_q <= base_q + word_cnt;
              data_q <= {byte_in, pack_reg[23:0]};
            end
          end
        end
        WRITE: begin
          if (word_cnt != LAST_WORD) word_cnt <= word_cnt + ONE;
        end
        default: ;
      endcase
    end
  end

  assign cpu_stall   = busy;
  assign dm_addr     = busy ? addr_q : cpu_addr;
  assign dm_re       = busy ? 1'b0 : cpu_re;
  assign dm_we       = busy ? (state == WRITE) : cpu_we;
  assign dm_wrt_data = busy ? data_q : cpu_wrt_data;

endmodule

// File: tb/tb_dm_img_loader.sv
// tb/tb_dm_img_loader.sv - directed bench for dm_img_loader with a behavioural DM
// DM is modelled as an array written on negedge; a write log and done counter back the checks.
module tb_dm_img_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [12:0] base_addr;
  logic [7:0]  byte_in;
  logic        byte_vld;
  logic        byte_rdy;
  logic [12:0] cpu_addr;
  logic        cpu_re;
  logic        cpu_we;
  logic [31:0] cpu_wrt_data;
  logic        cpu_stall;
  logic [12:0] dm_addr;
  logic        dm_re;
  logic        dm_we;
  logic [31:0] dm_wrt_data;
  logic        busy;
  logic        done;

  int vec = 0;
  int miscmp = 0;
  int done_cnt = 0;

  logic [31:0] mem [0:8191];
  logic [12:0] wr_addr [$];
  logic [31:0] wr_data [$];

  dm_img_loader #(.ADDR_W(13), .NUM_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .byte_in(byte_in), .byte_vld(byte_vld), .byte_rdy(byte_rdy),
    .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_wrt_data(cpu_wrt_data), .cpu_stall(cpu_stall),
    .dm_addr(dm_addr), .dm_re(dm_re), .dm_we(dm_we), .dm_wrt_data(dm_wrt_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dm_we) begin
      mem[dm_addr] <= dm_wrt_data;
      wr_addr.push_back(dm_addr);
      wr_data.push_back(dm_wrt_data);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  task automatic start_load(input logic [12:0] b);
    base_addr = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit sent = 1'b0;
    byte_in  = b;
    byte_vld = 1'b1;
    for (int t = 0; t < 20 && !sent; t++) begin
      if (byte_rdy) sent = 1'b1;
      @(posedge clk); #1;
    end
    vec++;
    if (!sent) begin
      miscmp++;
      $display("FAIL send_byte timeout: byte 0x%02h not accepted, required acceptance within 20 cycles", b);
    end
  endtask

  task automatic send_stream(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) send_byte(first + 8'(i));
    byte_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    vec++;
    if (busy) begin
      miscmp++;
      $display("FAIL wait_idle timeout: busy=%0d, required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (busy !== 1'b0)      begin miscmp++; $display("FAIL reset busy: got %0d want 0", busy); end
    vec++; if (done !== 1'b0)      begin miscmp++; $display("FAIL reset done: got %0d want 0", done); end
    vec++; if (byte_rdy !== 1'b0)  begin miscmp++; $display("FAIL reset byte_rdy: got %0d want 0", byte_rdy); end
    vec++; if (cpu_stall !== 1'b0) begin miscmp++; $display("FAIL reset cpu_stall: got %0d want 0", cpu_stall); end
    rst_n = 1'b1;
    cpu_addr = 13'h0055;
    cpu_re = 1'b1;
    #1;
    vec++; if (dm_addr !== 13'h0055) begin miscmp++; $display("FAIL idle passthrough addr: got 0x%0h want 0x55", dm_addr); end
    vec++; if (dm_re !== 1'b1)       begin miscmp++; $display("FAIL idle passthrough re: got %0d want 1", dm_re); end
    cpu_re = 1'b0;
    cpu_addr = 13'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_load();
    clear_log();
    start_load(13'h100);
    vec++; if (busy !== 1'b1) begin miscmp++; $display("FAIL basic busy after start: got %0d want 1", busy); end
    send_stream(8'h00, 16);
    wait_idle();
    vec++; if (mem[13'h100] !== 32'h03020100) begin miscmp++; $display("FAIL basic word0: got 0x%08h want 0x03020100", mem[13'h100]); end
    vec++; if (mem[13'h101] !== 32'h07060504) begin miscmp++; $display("FAIL basic word1: got 0x%08h want 0x07060504", mem[13'h101]); end
    vec++; if (mem[13'h102] !== 32'h0B0A0908) begin miscmp++; $display("FAIL basic word2: got 0x%08h want 0x0B0A0908", mem[13'h102]); end
    vec++; if (mem[13'h103] !== 32'h0F0E0D0C) begin miscmp++; $display("FAIL basic word3: got 0x%08h want 0x0F0E0D0C", mem[13'h103]); end
    vec++; if (wr_addr.size() != 4) begin miscmp++; $display("FAIL basic write count: got %0d want 4", wr_addr.size()); end
    vec++; if (done_cnt != 1) begin miscmp++; $display("FAIL basic done pulses: got %0d want 1", done_cnt); end
  endtask

  task automatic test_addr_wrap();
    logic [12:0] exp_a [4];
    exp_a[0] = 13'h1FFE; exp_a[1] = 13'h1FFF; exp_a[2] = 13'h0000; exp_a[3] = 13'h0001;
    clear_log();
    start_load(13'h1FFE);
    send_stream(8'h10, 16);
    wait_idle();
    vec++; if (wr_addr.size() != 4) begin miscmp++; $display("FAIL wrap write count: got %0d want 4", wr_addr.size()); end
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      vec++;
      if (wr_addr[i] !== exp_a[i]) begin miscmp++; $display("FAIL wrap addr[%0d]: got 0x%0h want 0x%0h", i, wr_addr[i], exp_a[i]); end
    end
    vec++; if (mem[13'h0000] !== 32'h1B1A1918) begin miscmp++; $display("FAIL wrap word2: got 0x%08h want 0x1B1A1918", mem[13'h0000]); end
    vec++; if (mem[13'h1FFF] !== 32'h17161514) begin miscmp++; $display("FAIL wrap word1: got 0x%08h want 0x17161514", mem[13'h1FFF]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] nxt = 8'h40;
    bit exp_rdy, exp_we, exp_done;
    clear_log();
    start_load(13'h500);
    byte_vld = 1'b1;
    for (int c = 0; c < 22; c++) begin
      exp_rdy  = (c < 20) && (c % 5 != 4);
      exp_we   = (c < 20) && (c % 5 == 4);
      exp_done = (c == 20);
      byte_in = nxt;
      vec++; if (byte_rdy !== exp_rdy) begin miscmp++; $display("FAIL b2b byte_rdy cyc %0d: got %0d want %0d", c, byte_rdy, exp_rdy); end
      vec++; if (dm_we !== exp_we)     begin miscmp++; $display("FAIL b2b dm_we cyc %0d: got %0d want %0d", c, dm_we, exp_we); end
      vec++; if (done !== exp_done)    begin miscmp++; $display("FAIL b2b done cyc %0d: got %0d want %0d", c, done, exp_done); end
      @(posedge clk); #1;
      if (exp_rdy) nxt = nxt + 8'd1;
    end
    byte_vld = 1'b0;
    vec++; if (mem[13'h500] !== 32'h43424140) begin miscmp++; $display("FAIL b2b word0: got 0x%08h want 0x43424140", mem[13'h500]); end
    vec++; if (mem[13'h501] !== 32'h47464544) begin miscmp++; $display("FAIL b2b word1: got 0x%08h want 0x47464544", mem[13'h501]); end
    vec++; if (mem[13'h502] !== 32'h4B4A4948) begin miscmp++; $display("FAIL b2b word2: got 0x%08h want 0x4B4A4948", mem[13'h502]); end
    vec++; if (mem[13'h503] !== 32'h4F4E4D4C) begin miscmp++; $display("FAIL b2b word3: got 0x%08h want 0x4F4E4D4C", mem[13'h503]); end
    vec++; if (busy !== 1'b0) begin miscmp++; $display("FAIL b2b busy at end: got %0d want 0", busy); end
  endtask

  task automatic test_cpu_stall();
    clear_log();
    mem[13'h010] = 32'h11111111;
    start_load(13'h200);
    send_stream(8'h20, 2);
    cpu_addr = 13'h010;
    cpu_wrt_data = 32'hDEADBEEF;
    cpu_we = 1'b1;
    #1;
    vec++; if (cpu_stall !== 1'b1) begin miscmp++; $display("FAIL stall cpu_stall: got %0d want 1", cpu_stall); end
    vec++; if (dm_we !== 1'b0)     begin miscmp++; $display("FAIL stall dm_we in fill: got %0d want 0", dm_we); end
    send_stream(8'h22, 14);
    wait_idle();
    vec++; if (mem[13'h010] !== 32'h11111111) begin miscmp++; $display("FAIL stall DM[0x10] during load: got 0x%08h want 0x11111111", mem[13'h010]); end
    vec++; if (wr_addr.size() != 4) begin miscmp++; $display("FAIL stall write count: got %0d want 4", wr_addr.size()); end
    vec++; if (mem[13'h203] !== 32'h2F2E2D2C) begin miscmp++; $display("FAIL stall word3: got 0x%08h want 0x2F2E2D2C", mem[13'h203]); end
    @(negedge clk); #1;
    vec++; if (mem[13'h010] !== 32'hDEADBEEF) begin miscmp++; $display("FAIL stall idle cpu write: got 0x%08h want 0xDEADBEEF", mem[13'h010]); end
    cpu_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    start_load(13'h300);
    send_stream(8'h00, 6);
    rst_n = 1'b0;
    #1;
    vec++; if (busy !== 1'b0)     begin miscmp++; $display("FAIL midreset busy: got %0d want 0", busy); end
    vec++; if (byte_rdy !== 1'b0) begin miscmp++; $display("FAIL midreset byte_rdy: got %0d want 0", byte_rdy); end
    repeat (3) @(posedge clk);
    #1;
    vec++; if (wr_addr.size() != 1) begin miscmp++; $display("FAIL midreset write count: got %0d want 1", wr_addr.size()); end
    vec++; if (mem[13'h300] !== 32'h03020100) begin miscmp++; $display("FAIL midreset word0: got 0x%08h want 0x03020100", mem[13'h300]); end
    vec++; if (mem[13'h301] !== 32'h0) begin miscmp++; $display("FAIL midreset partial word: got 0x%08h want 0x0", mem[13'h301]); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_log();
    start_load(13'h300);
    send_stream(8'hA0, 16);
    wait_idle();
    vec++; if (mem[13'h300] !== 32'hA3A2A1A0) begin miscmp++; $display("FAIL reload word0: got 0x%08h want 0xA3A2A1A0", mem[13'h300]); end
    vec++; if (mem[13'h303] !== 32'hAFAEADAC) begin miscmp++; $display("FAIL reload word3: got 0x%08h want 0xAFAEADAC", mem[13'h303]); end
    vec++; if (done_cnt != 1) begin miscmp++; $display("FAIL reload done pulses: got %0d want 1", done_cnt); end
  endtask

  task automatic test_restart_ignored();
    clear_log();
    start_load(13'h400);
    send_stream(8'h60, 5);
    start_load(13'h800);
    send_stream(8'h65, 11);
    wait_idle();
    vec++; if (wr_addr.size() != 4) begin miscmp++; $display("FAIL restart write count: got %0d want 4", wr_addr.size()); end
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      vec++;
      if (wr_addr[i] !== 13'(13'h400 + i)) begin miscmp++; $display("FAIL restart addr[%0d]: got 0x%0h want 0x%0h", i, wr_addr[i], 13'h400 + i); end
    end
    vec++; if (mem[13'h401] !== 32'h67666564) begin miscmp++; $display("FAIL restart word1: got 0x%08h want 0x67666564", mem[13'h401]); end
    vec++; if (mem[13'h403] !== 32'h6F6E6D6C) begin miscmp++; $display("FAIL restart word3: got 0x%08h want 0x6F6E6D6C", mem[13'h403]); end
    vec++; if (done_cnt != 1) begin miscmp++; $display("FAIL restart done pulses: got %0d want 1", done_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = 13'h0;
    byte_in = 8'h0;
    byte_vld = 1'b0;
    cpu_addr = 13'h0;
    cpu_re = 1'b0;
    cpu_we = 1'b0;
    cpu_wrt_data = 32'h0;
    test_reset();
    test_basic_load();
    test_addr_wrap();
    test_back_to_back();
    test_cpu_stall();
    test_reset_mid_load();
    test_restart_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
